// File: rtl/aes_cnt_regs_pkg.sv
// Shared AES top package: bus geometry, counter register offsets,
// CTRL bit positions and the register-select encoding.
package aes_cnt_regs_pkg;

  localparam int ADDRESS_SIZE      = 32;
  localparam int REG_SIZE          = 32;
  localparam int WORD_COUNTER_SIZE = 8;

  localparam logic [31:0] PERIPHERAL_ADDR = 32'h0000_1000;

  // Byte offsets of the statistics registers from the peripheral base
  localparam logic [31:0] MSG_CNT_OFFSET     = 32'h0;
  localparam logic [31:0] ADDER_CNT_OFFSET   = 32'h4;
  localparam logic [31:0] REMOVER_CNT_OFFSET = 32'h8;
  localparam logic [31:0] CTRL_OFFSET        = 32'hC;

  // CTRL register bit positions
  localparam int CTRL_COUNT_EN_BIT  = 0;
  localparam int CTRL_CLEAR_ALL_BIT = 1;

  // Which register (if any) the current bus address points at
  typedef enum logic [2:0] {
    REG_MSG,
    REG_ADDER,
    REG_REMOVER,
    REG_CTRL,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/aes_beat_counter.sv
// One stream beat counter with a sticky overflow flag.
// Priority on a given edge: clear, then load, then increment.
module aes_beat_counter
  import aes_cnt_regs_pkg::*;
#(
  parameter int WIDTH = WORD_COUNTER_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Next-state: clear beats a bus load, a bus load beats a stream beat
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
      ovf_d   = 1'b0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
      if (&count_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Counter and overflow state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/aes_cnt_regs.sv
// Avalon-MM statistics block counting beats on the msg, adder and
// remover streams, with a CTRL register for enable and bulk clear.
module aes_cnt_regs #(
  parameter int ADDRESS_SIZE      = aes_cnt_regs_pkg::ADDRESS_SIZE,
  parameter int REG_SIZE          = aes_cnt_regs_pkg::REG_SIZE,
  parameter int WORD_COUNTER_SIZE = aes_cnt_regs_pkg::WORD_COUNTER_SIZE,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR =
    ADDRESS_SIZE'(aes_cnt_regs_pkg::PERIPHERAL_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRESS_SIZE-1:0] avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [REG_SIZE-1:0]     avs_writedata,
  output logic [REG_SIZE-1:0]     avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    avs_waitrequest,
  input  logic                    msg_vld,
  input  logic                    msg_rdy,
  input  logic                    adder_vld,
  input  logic                    adder_rdy,
  input  logic                    remover_vld,
  input  logic                    remover_rdy,
  output logic [2:0]              cnt_ovf
);

  import aes_cnt_regs_pkg::*;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  reg_sel_e                     reg_sel;
  logic                         wr_accept, rd_accept, clear_all;
  logic                         count_en_q, count_en_d;
  logic [0:0]                   state_q, state_d;
  logic [REG_SIZE-1:0]          rdata_q, rdata_d;
  logic [WORD_COUNTER_SIZE-1:0] msg_cnt, adder_cnt, remover_cnt;
  logic                         msg_ovf, adder_ovf, remover_ovf;
  logic                         unused_wdata;

  assign avs_waitrequest = 1'b0;
  assign wr_accept       = avs_write;
  assign rd_accept       = avs_read && !avs_write;
  assign clear_all       = wr_accept && (reg_sel == REG_CTRL) &&
                           avs_writedata[CTRL_CLEAR_ALL_BIT];
  assign unused_wdata    = ^avs_writedata[REG_SIZE-1:WORD_COUNTER_SIZE];

  // Exact-match address decode; anything else, unaligned included, is no register
  always_comb begin
    reg_sel = REG_NONE;
    if (avs_address == BASE_ADDR + ADDRESS_SIZE'(MSG_CNT_OFFSET)) begin
      reg_sel = REG_MSG;
    end else if (avs_address == BASE_ADDR + ADDRESS_SIZE'(ADDER_CNT_OFFSET)) begin
      reg_sel = REG_ADDER;
    end else if (avs_address == BASE_ADDR + ADDRESS_SIZE'(REMOVER_CNT_OFFSET)) begin
      reg_sel = REG_REMOVER;
    end else if (avs_address == BASE_ADDR + ADDRESS_SIZE'(CTRL_OFFSET)) begin
      reg_sel = REG_CTRL;
    end
  end

  aes_beat_counter #(.WIDTH(WORD_COUNTER_SIZE)) u_msg_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_all),
    .load_i     (wr_accept && (reg_sel == REG_MSG)),
    .load_val_i (avs_writedata[WORD_COUNTER_SIZE-1:0]),
    .inc_i      (count_en_q && msg_vld && msg_rdy),
    .count_o    (msg_cnt),
    .ovf_o      (msg_ovf)
  );

  aes_beat_counter #(.WIDTH(WORD_COUNTER_SIZE)) u_adder_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_all),
    .load_i     (wr_accept && (reg_sel == REG_ADDER)),
    .load_val_i (avs_writedata[WORD_COUNTER_SIZE-1:0]),
    .inc_i      (count_en_q && adder_vld && adder_rdy),
    .count_o    (adder_cnt),
    .ovf_o      (adder_ovf)
  );

  aes_beat_counter #(.WIDTH(WORD_COUNTER_SIZE)) u_remover_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_all),
    .load_i     (wr_accept && (reg_sel == REG_REMOVER)),
    .load_val_i (avs_writedata[WORD_COUNTER_SIZE-1:0]),
    .inc_i      (count_en_q && remover_vld && remover_rdy),
    .count_o    (remover_cnt),
    .ovf_o      (remover_ovf)
  );

  // Snapshot the selected register (pre-increment) on an accepted read, zero otherwise
  always_comb begin
    rdata_d    = '0;
    count_en_d = count_en_q;
    state_d    = rd_accept ? ST_RESP : ST_IDLE;
    if (wr_accept && (reg_sel == REG_CTRL)) begin
      count_en_d = avs_writedata[CTRL_COUNT_EN_BIT];
    end
    if (rd_accept) begin
      case (reg_sel)
        REG_MSG: begin
          rdata_d[WORD_COUNTER_SIZE-1:0] = msg_cnt;
          rdata_d[WORD_COUNTER_SIZE]     = msg_ovf;
        end
        REG_ADDER: begin
          rdata_d[WORD_COUNTER_SIZE-1:0] = adder_cnt;
          rdata_d[WORD_COUNTER_SIZE]     = adder_ovf;
        end
        REG_REMOVER: begin
          rdata_d[WORD_COUNTER_SIZE-1:0] = remover_cnt;
          rdata_d[WORD_COUNTER_SIZE]     = remover_ovf;
        end
        REG_CTRL: begin
          rdata_d[CTRL_COUNT_EN_BIT] = count_en_q;
        end
        default: begin
          rdata_d = '0;
        end
      endcase
    end
  end

  // Read-response FSM, read data and count enable; reset aborts any pending read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      count_en_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      count_en_q <= count_en_d;
    end
  end

  assign avs_readdatavalid = (state_q == ST_RESP);
  assign avs_readdata      = rdata_q;
  assign cnt_ovf           = {remover_ovf, adder_ovf, msg_ovf};

endmodule

// File: doc/aes_cnt_regs.md
AES_CNT_REGS -- requirements
Module: aes_cnt_regs

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- ADDRESS_SIZE, 32, Avalon-MM address width.
- REG_SIZE, 32, Avalon-MM data width.
- WORD_COUNTER_SIZE, 8, counter width.
- BASE_ADDR, 'h1000, peripheral base address.
REQ-002 The block SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous and active-high.
- avs_address, in, ADDRESS_SIZE: byte address.
- avs_read, in, 1: read request.
- avs_write, in, 1: write request.
- avs_writedata, in, REG_SIZE: write data.
- avs_readdata, out, REG_SIZE: read data.
- avs_readdatavalid, out, 1: read data valid.
- avs_waitrequest, out, 1: stall; tied 0.
- msg_vld / msg_rdy, in, 1 each: word-generator stream beat.
- adder_vld / adder_rdy, in, 1 each: adder output stream beat.
- remover_vld / remover_rdy, in, 1 each: remover output stream beat.
- cnt_ovf, out, 3: sticky overflow flags; bit0 msg, bit1 adder, bit2 remover.

Function
REQ-003 Each stream SHALL count a beat on every cycle where its vld and rdy are both 1; the rdy signals are observed only, never driven.
REQ-004 Counters SHALL be WORD_COUNTER_SIZE bits and wrap from 255 to 0. On wrap, the stream's sticky overflow bit SHALL be set.
REQ-005 Counting SHALL occur only while CTRL.count_en = 1.
REQ-006 Register map (offset from BASE_ADDR):
- 'h0: MSG counter.
- 'h4: ADDER counter.
- 'h8: REMOVER counter.
- 'hC: CTRL.
REQ-007 Counter register read format SHALL be [7:0] count, [8] overflow, all other bits 0.
REQ-008 A write to a counter register SHALL load count from writedata[7:0] and clear its overflow bit.
REQ-009 CTRL SHALL have these fields:
- bit0 count_en: read/write.
- bit1 clear_all: write-1 pulse; clears all counts and overflows on the next edge; reads as 0.
- All other bits: read as 0.
REQ-010 A read SHALL be accepted in the cycle avs_read = 1. avs_readdatavalid SHALL be 1 exactly one cycle later, with avs_readdata holding the register value from the acceptance cycle, before that cycle's increment.
REQ-011 Back-to-back reads SHALL be supported at one per cycle, with one-cycle latency each.
REQ-012 Any address outside the four offsets (including unaligned) SHALL read as 0 with readdatavalid still returned; writes to such addresses SHALL be ignored.
REQ-013 If a write and a beat target the same counter in the same cycle, the write SHALL win and the beat SHALL be dropped.
REQ-014 clear_all SHALL take priority over a simultaneous beat.
REQ-015 If avs_read and avs_write are asserted in the same cycle, the write SHALL execute and the read SHALL be ignored (no readdatavalid).
REQ-016 avs_readdata SHALL be 0 whenever avs_readdatavalid = 0.
REQ-017 The read path SHALL be a two-state FSM:
- IDLE -> RESP on an accepted read.
- RESP -> RESP on another read; RESP -> IDLE otherwise.
- avs_readdatavalid = 1 in RESP only.
REQ-018 cnt_ovf SHALL mirror the three overflow bits combinationally from registers.

Reset
REQ-019 While rst = 1 at a clk edge, the block SHALL set:
- all counts = 0 and all overflows = 0;
- count_en = 1;
- FSM = IDLE, avs_readdatavalid = 0, avs_readdata = 0.
REQ-020 A read accepted in the same cycle as reset SHALL be discarded; a read pending in RESP when reset asserts SHALL be aborted (no readdatavalid after reset).

Structure
REQ-021 Offsets 'h0/'h4/'h8, the new CTRL offset 'hC, PERIPHERAL_ADDR, ADDRESS_SIZE, REG_SIZE and WORD_COUNTER_SIZE SHALL come from the shared AES top package.
REQ-022 The CTRL bit indices and a register-select enum SHALL also be added to that package.
REQ-023 One sub-module, aes_beat_counter (one counter plus sticky overflow, with load/clear/inc ports), SHALL be instantiated three times.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read 'h1000/'h1004/'h1008/'h100C -> 0, 0, 0, 'h1, each with readdatavalid one cycle after its read.
- 5 msg beats, plus 2 cycles of msg_vld = 1 with msg_rdy = 0 -> read 'h1000 returns 'h5.
- Write 'h1004 = 'hFE, then 3 adder beats -> read returns 'h101, cnt_ovf = 3'b010; write 'h1004 = 0 -> read returns 'h0, cnt_ovf = 0.
- Remover beat in the same cycle as a write of 'h1008 = 'h10 -> read returns 'h10; beat with CTRL = 0 -> count unchanged.
- Write CTRL = 'h3 with beats active -> all counters read 0 next cycle; CTRL reads 'h1; read 'h1010 -> 0.
- Reads on 3 consecutive cycles followed by rst in the 4th cycle -> exactly 3 readdatavalid pulses; all values 0 after reset.
